wb_data_bus_arbiter: RTL and testbench
======================================

// Module: wb_data_bus_arbiter
// PURPOSE
// Shares one Wishbone (WB4) slave port between two masters: M0 = load/store state machine, M1 = instruction fetch.
// Registered arbitration; grant is held for a whole bus transaction, or across several when the master asserts lock.
// Lock keeps read-modify-write and unaligned two-word sequences atomic.
// A watchdog terminates transactions the slave never acknowledges and returns an error to the owning master.
// PARAMETERS
// TIMEOUT_CYCLES  255  stalled STB cycles without s_ack before abort; legal range 2..255
// ROUND_ROBIN     1    1 = tie goes to the master not served last; 0 = M0 always wins ties
// PORTS
// clk        in   1   clock
// rst        in   1   reset, synchronous, active-high
// m0_cyc     in   1   M0 cycle request
// m0_stb     in   1   M0 strobe
// m0_we      in   1   M0 write enable
// m0_adr     in   32  M0 address
// m0_dat_o   in   32  M0 write data
// m0_lock    in   1   M0 holds grant across CYC drops
// m0_ack     out  1   ack routed to M0
// m0_err     out  1   timeout error pulse to M0
// m1_cyc, m1_stb, m1_we, m1_adr[31:0], m1_dat_o[31:0], m1_lock  in   same meaning as the M0 ports, for M1
// m1_ack, m1_err                                                 out  same meaning as the M0 ports, for M1
// m_dat_i    out  32  read data, broadcast to both masters (= s_dat_i)
// s_cyc      out  1   slave cycle
// s_stb      out  1   slave strobe
// s_we       out  1   slave write enable
// s_adr      out  32  slave address
// s_dat_o    out  32  slave write data
// s_dat_i    in   32  slave read data
// s_ack      in   1   slave acknowledge
// grant      out  2   one-hot owner: 01 = M0, 10 = M1, 00 = none
// BEHAVIOUR
// - Reset: state IDLE; last_grant = M1, so the first tie goes to M0; timeout counter 0.
//   Reset values: grant = 00; s_cyc, s_stb, s_we, mX_ack, mX_err = 0; s_adr and s_dat_o = 0. m_dat_i is always s_dat_i.
// - FSM states: IDLE, OWN0, OWN1.
// - IDLE: s_* outputs are all 0.
//   Requests sampled on mX_cyc. Single request -> OWNx next cycle.
//   Both requesting -> winner chosen by ROUND_ROBIN / last_grant. Neither -> stay IDLE.
//   Latency: m_cyc high in cycle N -> s_cyc high in cycle N+1.
// - OWNx: s_cyc, s_stb, s_we, s_adr and s_dat_o combinationally mirror master x.
//   mx_ack = s_ack; the other master's ack and err are 0.
//   grant reflects x; last_grant <= x on entry.
// - Release: in OWNx, when mx_cyc = 0 and mx_lock = 0 -> IDLE next cycle.
//   This gives at least one IDLE cycle between owners; no direct OWN0 -> OWN1 transition.
// - Lock: while mx_lock = 1, OWNx persists even with mx_cyc = 0. s_cyc and s_stb follow the master (low).
//   The other master is starved until lock drops.
// - Watchdog: counter increments each OWNx cycle with mx_stb = 1 and s_ack = 0.
//   The counter clears on s_ack, on mx_stb = 0, or on leaving OWNx. It saturates at TIMEOUT_CYCLES.
//   When count == TIMEOUT_CYCLES: mx_err = 1 for that cycle; s_cyc and s_stb forced 0; mx_ack = 0; next state IDLE.
//   The abort ignores lock.
// - Simultaneous s_ack and timeout in the same cycle: ack wins, err = 0, counter clears.
// - Reset mid-transaction: the next cycle is IDLE with all outputs at reset values. No ack or err is emitted.
// TESTING
// - M1 only, read adr 0x100; slave acks 2 cycles after s_stb with s_dat_i 0xDEADBEEF:
//   -> s_cyc rises 1 cycle after m1_cyc; m1_ack pulses once; m_dat_i = 0xDEADBEEF; m0_ack = 0; grant = 10.
// - M1 write adr 0x40, data 0x12345678:
//   -> s_we = 1, s_adr = 0x40, s_dat_o = 0x12345678 while grant = 10.
// - Both request in the first cycle after reset:
//   -> M0 is served first; one IDLE cycle; then M1 is served.
//   -> With ROUND_ROBIN = 1, the next tie goes to M0; with ROUND_ROBIN = 0, every tie goes to M0.
// - M0 lock = 1 while it reads 0x204, drops CYC, then writes 0x204 and 0x208; M1 requests continuously:
//   -> grant stays 01 throughout; M1 is granted only after lock = 0 and m0_cyc = 0.
// - TIMEOUT_CYCLES = 8, M0 strobes and the slave never acks:
//   -> m0_err is a single-cycle pulse on the 9th stalled cycle; s_cyc = 0 that cycle; FSM in IDLE the next cycle.
// - Reset asserted during OWN1 with s_stb high:
//   -> next cycle s_cyc = 0, grant = 00, m1_ack = 0, m1_err = 0.

Source files
------------

// File: rtl/wb_data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_data_bus_arbiter
//
// Shares one Wishbone (WB4) slave port between two masters:
//   M0 = load/store state machine, M1 = instruction fetch.
// Arbitration is registered. The owner keeps the grant for a whole bus
// transaction, or for several transactions while it holds its lock input, so
// read-modify-write and unaligned two-word sequences stay atomic.
// A watchdog aborts a strobe the slave never acknowledges and returns a
// one-cycle error pulse to the owning master.
//
// Parameters
//   TIMEOUT_CYCLES : stalled strobe cycles tolerated before the abort (2..255)
//   ROUND_ROBIN    : 1 = a tie goes to the master not served last,
//                    0 = M0 always wins a tie
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   mX_cyc/stb/we/adr/dat_o   master X bus request (X = 0, 1)
//   mX_lock                   master X keeps the grant across CYC drops
//   mX_ack, mX_err            acknowledge / timeout error routed to master X
//   m_dat_i                   read data broadcast to both masters (= s_dat_i)
//   s_cyc/stb/we/adr/dat_o    slave-side request, mirrors the owning master
//   s_dat_i, s_ack            slave read data and acknowledge
//   grant                     one-hot owner: 01 = M0, 10 = M1, 00 = none
// -----------------------------------------------------------------------------
module wb_data_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit ROUND_ROBIN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (load/store)
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_o,
  input  logic        m0_lock,
  output logic        m0_ack,
  output logic        m0_err,
  // master 1 (instruction fetch)
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_o,
  input  logic        m1_lock,
  output logic        m1_ack,
  output logic        m1_err,
  // shared read data
  output logic [31:0] m_dat_i,
  // slave port
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack,
  // current owner
  output logic [1:0]  grant
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [7:0] TO_VAL = 8'(TIMEOUT_CYCLES);

  state_t      r_state;
  logic        r_last_m1;   // 1 when M1 was the most recent owner
  logic [7:0]  r_wd_cnt;    // stalled-strobe cycles of the current owner

  // Master requests packed so the owner can be selected by index.
  logic [1:0]  w_cyc;
  logic [1:0]  w_stb;
  logic [1:0]  w_we;
  logic [1:0]  w_lock;
  logic [31:0] w_adr [2];
  logic [31:0] w_dat [2];

  logic [1:0]  w_own;
  logic [1:0]  w_ack;
  logic [1:0]  w_err;
  logic        w_active;
  logic        w_sel;
  logic        w_timeout;
  logic        w_release;

  assign w_cyc    = {m1_cyc, m0_cyc};
  assign w_stb    = {m1_stb, m0_stb};
  assign w_we     = {m1_we, m0_we};
  assign w_lock   = {m1_lock, m0_lock};
  assign w_adr[0] = m0_adr;
  assign w_adr[1] = m1_adr;
  assign w_dat[0] = m0_dat_o;
  assign w_dat[1] = m1_dat_o;

  assign w_own    = r_state;
  assign w_active = |w_own;
  assign w_sel    = w_own[1];

  // Abort once the counter has reached the limit; an ack arriving in the same
  // cycle completes the transfer instead.
  assign w_timeout = w_active && (r_wd_cnt == TO_VAL) && !s_ack;

  // The owner lets go only when it has dropped both CYC and lock.
  assign w_release = !w_cyc[w_sel] && !w_lock[w_sel];

  // Slave side mirrors the owner; CYC/STB are pulled low in the abort cycle.
  assign s_cyc   = w_active && w_cyc[w_sel] && !w_timeout;
  assign s_stb   = w_active && w_stb[w_sel] && !w_timeout;
  assign s_we    = w_active && w_we[w_sel];
  assign s_adr   = w_active ? w_adr[w_sel] : 32'd0;
  assign s_dat_o = w_active ? w_dat[w_sel] : 32'd0;
  assign m_dat_i = s_dat_i;
  assign grant   = w_own;

  // Ack and err go to the owner only; w_timeout already excludes s_ack.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_route
      assign w_ack[gi] = w_own[gi] && s_ack;
      assign w_err[gi] = w_own[gi] && w_timeout;
    end
  endgenerate

  assign m0_ack = w_ack[0];
  assign m1_ack = w_ack[1];
  assign m0_err = w_err[0];
  assign m1_err = w_err[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last_m1 <= 1'b1;
      r_wd_cnt  <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wd_cnt <= 8'd0;
          if (m0_cyc && m1_cyc) begin
            if (ROUND_ROBIN && !r_last_m1) begin
              r_state   <= OWN1;
              r_last_m1 <= 1'b1;
            end else begin
              r_state   <= OWN0;
              r_last_m1 <= 1'b0;
            end
          end else if (m0_cyc) begin
            r_state   <= OWN0;
            r_last_m1 <= 1'b0;
          end else if (m1_cyc) begin
            r_state   <= OWN1;
            r_last_m1 <= 1'b1;
          end
        end

        OWN0, OWN1: begin
          // The abort overrides lock; always pass through IDLE between owners.
          if (w_timeout || w_release) begin
            r_state  <= IDLE;
            r_wd_cnt <= 8'd0;
          end else if (s_ack || !w_stb[w_sel]) begin
            r_wd_cnt <= 8'd0;
          end else if (r_wd_cnt != TO_VAL) begin
            r_wd_cnt <= r_wd_cnt + 8'd1;
          end
        end

        default: begin
          r_state  <= IDLE;
          r_wd_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for wb_data_bus_arbiter.
// dut    : TIMEOUT_CYCLES = 8, ROUND_ROBIN = 1
// dut_b  : TIMEOUT_CYCLES = 8, ROUND_ROBIN = 0 (shares all inputs with dut)
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_wb_data_bus_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m0_lock;
  logic [31:0] m0_adr, m0_dat_o;
  logic        m1_cyc, m1_stb, m1_we, m1_lock;
  logic [31:0] m1_adr, m1_dat_o;
  logic [31:0] s_dat_i;
  logic        s_ack;

  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m_dat_i, s_adr, s_dat_o;
  logic        s_cyc, s_stb, s_we;
  logic [1:0]  grant;

  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
  logic [31:0] b_m_dat_i, b_s_adr, b_s_dat_o;
  logic        b_s_cyc, b_s_stb, b_s_we;
  logic [1:0]  b_grant;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_data_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_o(m0_dat_o), .m0_lock(m0_lock), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_o(m1_dat_o), .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_err(m1_err),
    .m_dat_i(m_dat_i),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack(s_ack), .grant(grant)
  );

  wb_data_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ROUND_ROBIN(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_o(m0_dat_o), .m0_lock(m0_lock), .m0_ack(b_m0_ack), .m0_err(b_m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_o(m1_dat_o), .m1_lock(m1_lock), .m1_ack(b_m1_ack), .m1_err(b_m1_err),
    .m_dat_i(b_m_dat_i),
    .s_cyc(b_s_cyc), .s_stb(b_s_stb), .s_we(b_s_we), .s_adr(b_s_adr),
    .s_dat_o(b_s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack), .grant(b_grant)
  );

  task automatic drive_idle();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_lock = 0; m0_adr = '0; m0_dat_o = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_lock = 0; m1_adr = '0; m1_dat_o = '0;
    s_ack = 0; s_dat_i = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_lock = 1;
    m0_adr = $urandom; m0_dat_o = $urandom;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_lock = 1;
    m1_adr = $urandom; m1_dat_o = $urandom;
    s_ack = 1; s_dat_i = 32'hCAFE_0001;
    next_cycle();
    @(negedge clk);
    total++;
    if (grant !== 2'b00) begin
      bad++; $display("FAIL reset_grant: got %b expected 00", grant);
    end
    total++;
    if ({s_cyc, s_stb, s_we} !== 3'b000) begin
      bad++; $display("FAIL reset_ctl: got %b expected 000", {s_cyc, s_stb, s_we});
    end
    total++;
    if (s_adr !== 32'd0 || s_dat_o !== 32'd0) begin
      bad++; $display("FAIL reset_bus: got adr=%h dat=%h expected 0", s_adr, s_dat_o);
    end
    total++;
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin
      bad++; $display("FAIL reset_ackerr: got %b expected 0000", {m0_ack, m0_err, m1_ack, m1_err});
    end
    total++;
    if (m_dat_i !== 32'hCAFE_0001) begin
      bad++; $display("FAIL reset_mdat: got %h expected cafe0001", m_dat_i);
    end
    $display("test_reset: done");
    do_reset();
  endtask

  task automatic test_m1_read();
    int acks = 0;
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h100;
    @(negedge clk);
    total++;
    if (s_cyc !== 1'b0 || grant !== 2'b00) begin
      bad++; $display("FAIL read_latency0: got s_cyc=%b grant=%b expected 0/00", s_cyc, grant);
    end
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      s_ack   = (c == 3);
      s_dat_i = (c == 3) ? 32'hDEADBEEF : 32'h0;
      if (c == 4) begin m1_cyc = 0; m1_stb = 0; end
      @(negedge clk);
      if (m1_ack === 1'b1) acks++;
      if (c == 1) begin
        total++;
        if (s_cyc !== 1'b1 || grant !== 2'b10 || s_adr !== 32'h100 || s_we !== 1'b0) begin
          bad++; $display("FAIL read_start: got s_cyc=%b grant=%b adr=%h we=%b expected 1/10/100/0",
                          s_cyc, grant, s_adr, s_we);
        end
      end
      if (c == 3) begin
        total++;
        if (m1_ack !== 1'b1 || m_dat_i !== 32'hDEADBEEF || m0_ack !== 1'b0 || grant !== 2'b10) begin
          bad++; $display("FAIL read_ack: got m1_ack=%b dat=%h m0_ack=%b grant=%b expected 1/deadbeef/0/10",
                          m1_ack, m_dat_i, m0_ack, grant);
        end
      end
    end
    total++;
    if (acks != 1) begin
      bad++; $display("FAIL read_ack_count: got %0d expected 1", acks);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (grant !== 2'b00) begin
      bad++; $display("FAIL read_release: got grant=%b expected 00", grant);
    end
    $display("test_m1_read: acks=%0d", acks);
  endtask

  task automatic test_m1_write();
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h40; m1_dat_o = 32'h12345678;
    next_cycle();
    s_ack = 1;
    @(negedge clk);
    total++;
    if (s_we !== 1'b1 || s_adr !== 32'h40 || s_dat_o !== 32'h12345678 || grant !== 2'b10) begin
      bad++; $display("FAIL write_bus: got we=%b adr=%h dat=%h grant=%b expected 1/40/12345678/10",
                      s_we, s_adr, s_dat_o, grant);
    end
    total++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
      bad++; $display("FAIL write_ack: got m1_ack=%b m0_ack=%b expected 1/0", m1_ack, m0_ack);
    end
    next_cycle();
    drive_idle();
    next_cycle();
    $display("test_m1_write: done");
  endtask

  // Both masters request every IDLE cycle and drop CYC in the owned cycle,
  // so every arbitration is a tie.
  task automatic test_tie();
    logic [1:0] exp_rr;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'h20;
      @(negedge clk);
      total++;
      if (grant !== 2'b00 || b_grant !== 2'b00) begin
        bad++; $display("FAIL tie_idle%0d: got %b/%b expected 00/00", r, grant, b_grant);
      end
      next_cycle();
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      exp_rr = (r % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      total++;
      if (grant !== exp_rr) begin
        bad++; $display("FAIL tie_rr1_round%0d: got %b expected %b", r, grant, exp_rr);
      end
      total++;
      if (b_grant !== 2'b01) begin
        bad++; $display("FAIL tie_rr0_round%0d: got %b expected 01", r, b_grant);
      end
      next_cycle();
    end
    $display("test_tie: done");
  endtask

  task automatic test_lock();
    logic [1:0] exp_g;
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300;
    for (int c = 0; c <= 7; c++) begin
      case (c)
        0, 1: begin m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_lock = 1; m0_adr = 32'h204; end
        2:    begin m0_cyc = 0; m0_stb = 0; m0_lock = 1; end
        3:    begin m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h204; m0_dat_o = 32'hA5; end
        4:    begin m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h208; m0_dat_o = 32'h5A; end
        default: begin m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_lock = 0; end
      endcase
      s_ack = (c == 1 || c == 3 || c == 4);
      exp_g = (c == 0 || c == 6) ? 2'b00 : (c == 7) ? 2'b10 : 2'b01;
      @(negedge clk);
      total++;
      if (grant !== exp_g) begin
        bad++; $display("FAIL lock_grant_c%0d: got %b expected %b", c, grant, exp_g);
      end
      if (c == 1) begin
        total++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
          bad++; $display("FAIL lock_read_ack: got m0=%b m1=%b expected 1/0", m0_ack, m1_ack);
        end
      end
      if (c == 2) begin
        total++;
        if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin
          bad++; $display("FAIL lock_cyc_low: got cyc=%b stb=%b expected 0/0", s_cyc, s_stb);
        end
      end
      if (c == 4) begin
        total++;
        if (s_we !== 1'b1 || s_adr !== 32'h208 || s_dat_o !== 32'h5A) begin
          bad++; $display("FAIL lock_write2: got we=%b adr=%h dat=%h expected 1/208/5a", s_we, s_adr, s_dat_o);
        end
      end
      if (c == 7) begin
        total++;
        if (s_adr !== 32'h300) begin
          bad++; $display("FAIL lock_m1_adr: got %h expected 300", s_adr);
        end
      end
      next_cycle();
    end
    drive_idle();
    next_cycle();
    $display("test_lock: done");
  endtask

  // Cycle 9 of stalling aborts; the second round acks on the 9th stalled
  // cycle, where the ack must win over the abort.
  task automatic test_timeout();
    logic [7:0] exp_v, got_v;
    logic [1:0] g;
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h500;
    for (int c = 0; c <= 20; c++) begin
      s_ack = (c == 19);
      g = (c == 0 || c == 10) ? 2'b00 : 2'b01;
      // {grant, s_cyc, s_stb, m0_err, m0_ack, m1_ack, m1_err}
      exp_v = {g, (g == 2'b01 && c != 9), (g == 2'b01 && c != 9), (c == 9), (c == 19), 1'b0, 1'b0};
      @(negedge clk);
      got_v = {grant, s_cyc, s_stb, m0_err, m0_ack, m1_ack, m1_err};
      total++;
      if (got_v !== exp_v) begin
        bad++; $display("FAIL timeout_c%0d: got %b expected %b (grant,cyc,stb,err0,ack0,ack1,err1)",
                        c, got_v, exp_v);
      end
      next_cycle();
    end
    drive_idle();
    next_cycle();
    next_cycle();
    $display("test_timeout: done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h600;
    next_cycle();
    @(negedge clk);
    total++;
    if (grant !== 2'b10) begin
      bad++; $display("FAIL rstmid_own: got %b expected 10", grant);
    end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    s_ack = 1'b1;
    @(negedge clk);
    total++;
    if ({s_cyc, s_stb, grant, m1_ack, m1_err} !== 6'b000000) begin
      bad++; $display("FAIL rstmid_idle: got %b expected 000000 (cyc,stb,grant,ack1,err1)",
                      {s_cyc, s_stb, grant, m1_ack, m1_err});
    end
    next_cycle();
    s_ack = 1'b0;
    @(negedge clk);
    total++;
    if (grant !== 2'b10) begin
      bad++; $display("FAIL rstmid_regrant: got %b expected 10", grant);
    end
    drive_idle();
    next_cycle();
    next_cycle();
    $display("test_reset_mid: done");
  endtask

  // Random masters/slave against a cycle model of the arbitration rules.
  task automatic test_random();
    int owner = -1;      // -1 = nobody, else master index
    int last  = 1;       // master served most recently
    int stall = 0;       // consecutive stalled strobe cycles of the owner
    int ack_pct = 40;
    int errs_seen = 0;
    bit mc[2], ms[2], mw[2], ml[2];
    logic [31:0] ma[2], md[2];
    bit to;
    logic [8:0] exp_v, got_v;
    logic [31:0] exp_a, exp_d;
    int cbad = 0;
    do_reset();
    for (int cyc = 0; cyc < 900; cyc++) begin
      if (cyc % 60 == 0) ack_pct = (($urandom % 3) == 0) ? 0 : 20 + 30 * ($urandom % 2);
      if (m0_cyc) m0_cyc = ($urandom % 6) != 0; else m0_cyc = ($urandom % 3) == 0;
      if (m1_cyc) m1_cyc = ($urandom % 6) != 0; else m1_cyc = ($urandom % 3) == 0;
      m0_stb = m0_cyc && (($urandom % 4) != 0);
      m1_stb = m1_cyc && (($urandom % 4) != 0);
      m0_we = $urandom % 2; m1_we = $urandom % 2;
      m0_lock = ($urandom % 10) == 0; m1_lock = ($urandom % 10) == 0;
      m0_adr = $urandom; m1_adr = $urandom; m0_dat_o = $urandom; m1_dat_o = $urandom;
      s_ack = ($urandom % 100) < ack_pct;
      s_dat_i = $urandom;
      mc[0] = m0_cyc; ms[0] = m0_stb; mw[0] = m0_we; ml[0] = m0_lock; ma[0] = m0_adr; md[0] = m0_dat_o;
      mc[1] = m1_cyc; ms[1] = m1_stb; mw[1] = m1_we; ml[1] = m1_lock; ma[1] = m1_adr; md[1] = m1_dat_o;
      @(negedge clk);
      // expected: {grant, s_cyc, s_stb, s_we, m0_ack, m0_err, m1_ack, m1_err}
      exp_v = '0; exp_a = '0; exp_d = '0; to = 0;
      if (owner >= 0) begin
        to = (stall == TO) && !s_ack;
        exp_v[8:7] = (owner == 0) ? 2'b01 : 2'b10;
        exp_v[6] = mc[owner] && !to;
        exp_v[5] = ms[owner] && !to;
        exp_v[4] = mw[owner];
        if (owner == 0) begin exp_v[3] = s_ack; exp_v[2] = to; end
        else            begin exp_v[1] = s_ack; exp_v[0] = to; end
        exp_a = ma[owner];
        exp_d = md[owner];
      end
      if (to) errs_seen++;
      got_v = {grant, s_cyc, s_stb, s_we, m0_ack, m0_err, m1_ack, m1_err};
      total++;
      if (got_v !== exp_v) begin
        bad++; cbad++;
        $display("FAIL rand_ctl cycle %0d: got %b expected %b (grant,cyc,stb,we,ack0,err0,ack1,err1)",
                 cyc, got_v, exp_v);
      end
      total++;
      if (s_adr !== exp_a || s_dat_o !== exp_d || m_dat_i !== s_dat_i) begin
        bad++; cbad++;
        $display("FAIL rand_bus cycle %0d: got adr=%h dat=%h expected adr=%h dat=%h",
                 cyc, s_adr, s_dat_o, exp_a, exp_d);
      end
      // advance the model to the next cycle
      if (owner < 0) begin
        if (mc[0] && mc[1]) owner = (last == 1) ? 0 : 1;
        else if (mc[0])     owner = 0;
        else if (mc[1])     owner = 1;
        if (owner >= 0) last = owner;
        stall = 0;
      end else if (to || (!mc[owner] && !ml[owner])) begin
        owner = -1;
        stall = 0;
      end else if (s_ack || !ms[owner]) begin
        stall = 0;
      end else if (stall < TO) begin
        stall++;
      end
      next_cycle();
      if (cbad > 20) break;
    end
    drive_idle();
    next_cycle();
    $display("test_random: timeouts=%0d", errs_seen);
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_m1_read();
    test_m1_write();
    test_tie();
    test_lock();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
